// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode, forwarding-select and FSM state encodings for the vector execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_SLT = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RSV = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_e;

endpackage

// File: rtl/exec_alu_lane.sv
// exec_alu_lane: combinational single-lane ALU for every op except MUL (MUL yields 0 here).
// Build option EXEC_SAT_EN: ADD/SUB clamp to the signed lane range instead of wrapping.
module exec_alu_lane
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_y
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;
    logic [SHW-1:0]          w_sh;
    alu_op_e                 w_op;

`ifdef EXEC_SAT_EN
    // One guard bit detects signed overflow; clamp toward the overflowed side.
    function automatic logic [WIDTH-1:0] addsub(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y,
                                                input logic sub);
        logic signed [WIDTH:0] s;
        s = sub ? ({x[WIDTH-1], x} - {y[WIDTH-1], y}) : ({x[WIDTH-1], x} + {y[WIDTH-1], y});
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] addsub(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y,
                                                input logic sub);
        return sub ? (x - y) : (x + y);
    endfunction
`endif

    assign w_sa = i_a;
    assign w_sb = i_b;
    assign w_sh = i_b[SHW-1:0];
    assign w_op = alu_op_e'(i_op);

    always_comb begin
        o_y = '0;
        case (w_op)
            OP_ADD:  o_y = addsub(w_sa, w_sb, 1'b0);
            OP_SUB:  o_y = addsub(w_sa, w_sb, 1'b1);
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SLL:  o_y = i_a << w_sh;
            OP_SRL:  o_y = i_a >> w_sh;
            OP_SRA:  o_y = w_sa >>> w_sh;
            OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, (w_sa < w_sb)};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/exec_vec.sv
// exec_vec: LANES-wide execute stage with operand forwarding, iterative shift-add multiplier
// and the EX/MEM register. EXEC_SAT_EN (see exec_alu_lane) selects saturating ADD/SUB.
module exec_vec
    import exec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int REGW  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] rd1,
    input  logic [LANES*WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0]       imm,
    input  logic [LANES*WIDTH-1:0] fwd_mem,
    input  logic [LANES*WIDTH-1:0] fwd_wb,
    input  logic [1:0]             fa,
    input  logic [1:0]             fb,
    input  logic [3:0]             alu_ctrl,
    input  logic                   imm_src,
    input  logic [REGW-1:0]        rc,
    input  logic                   mem_write,
    input  logic                   mem_to_reg,
    input  logic                   reg_write,
    output logic                   busy,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES*WIDTH-1:0] out_rd3,
    output logic [REGW-1:0]        out_rc,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic                   out_reg_write,
    output logic                   zero_flag
);

    localparam int            VW       = LANES * WIDTH;
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    exec_state_e     r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_is_mul, w_mul_issue, w_mul_step;
    logic [VW-1:0]   w_bfwd, w_alu, w_prod;

    logic [REGW-1:0] r_rc_p0;
    logic            r_mw_p0, r_mtr_p0, r_rw_p0;
    logic [VW-1:0]   r_rd3_p0;

    logic            w_ld, w_nx_valid, w_nx_mw, w_nx_mtr, w_nx_rw;
    logic [VW-1:0]   w_nx_result, w_nx_rd3;
    logic [REGW-1:0] w_nx_rc;

    assign w_is_mul = (alu_ctrl == OP_MUL);

    // ---- stage p0: operand select, lane ALUs, multiplier datapath ----
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_a, w_bf, w_b;
        logic [WIDTH-1:0] r_mcand_p0, r_mplier_p0, r_prod_p0;

        always_comb begin
            case (fwd_sel_e'(fa))
                FWD_MEM: w_a = fwd_mem[i*WIDTH +: WIDTH];
                FWD_WB:  w_a = fwd_wb[i*WIDTH +: WIDTH];
                default: w_a = rd1[i*WIDTH +: WIDTH];
            endcase
            case (fwd_sel_e'(fb))
                FWD_MEM: w_bf = fwd_mem[i*WIDTH +: WIDTH];
                FWD_WB:  w_bf = fwd_wb[i*WIDTH +: WIDTH];
                default: w_bf = rd2[i*WIDTH +: WIDTH];
            endcase
        end

        assign w_b = imm_src ? imm : w_bf;
        assign w_bfwd[i*WIDTH +: WIDTH] = w_bf;
        assign w_prod[i*WIDTH +: WIDTH] = r_prod_p0;

        exec_alu_lane #(.WIDTH(WIDTH)) u_lane (
            .i_a  (w_a),
            .i_b  (w_b),
            .i_op (alu_ctrl),
            .o_y  (w_alu[i*WIDTH +: WIDTH])
        );

        // Multiplicand walks left while multiplier bits are consumed from the LSB.
        always_ff @(posedge clk) begin
            if (w_mul_issue) begin
                r_mcand_p0  <= w_a;
                r_mplier_p0 <= w_b;
                r_prod_p0   <= '0;
            end else if (w_mul_step) begin
                if (r_mplier_p0[0])
                    r_prod_p0 <= r_prod_p0 + r_mcand_p0;
                r_mcand_p0  <= r_mcand_p0 << 1;
                r_mplier_p0 <= r_mplier_p0 >> 1;
            end
        end
    end

    // Sideband of the multiply is latched at issue so DONE does not depend on stalled inputs.
    always_ff @(posedge clk) begin
        if (w_mul_issue) begin
            r_rc_p0  <= rc;
            r_mw_p0  <= mem_write;
            r_mtr_p0 <= mem_to_reg;
            r_rw_p0  <= reg_write;
            r_rd3_p0 <= w_bfwd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mul_issue = 1'b0;
        w_mul_step  = 1'b0;
        busy = (r_state == ST_MUL) || ((r_state == ST_IDLE) && in_valid && w_is_mul);
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && w_is_mul) begin
                        w_mul_issue = 1'b1;
                        w_state_nxt = ST_MUL;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_MUL: begin
                    w_mul_step = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next bundle: product in DONE, bubble while stalled or empty, ALU result otherwise.
    always_comb begin
        w_ld        = 1'b0;
        w_nx_valid  = 1'b0;
        w_nx_result = '0;
        w_nx_rd3    = '0;
        w_nx_rc     = '0;
        w_nx_mw     = 1'b0;
        w_nx_mtr    = 1'b0;
        w_nx_rw     = 1'b0;
        if (flush) begin
            w_ld = 1'b1;
        end else if (en) begin
            w_ld = 1'b1;
            if (r_state == ST_DONE) begin
                w_nx_valid  = 1'b1;
                w_nx_result = w_prod;
                w_nx_rd3    = r_rd3_p0;
                w_nx_rc     = r_rc_p0;
                w_nx_mw     = r_mw_p0;
                w_nx_mtr    = r_mtr_p0;
                w_nx_rw     = r_rw_p0;
            end else if (!busy && in_valid) begin
                w_nx_valid  = 1'b1;
                w_nx_result = w_alu;
                w_nx_rd3    = w_bfwd;
                w_nx_rc     = rc;
                w_nx_mw     = mem_write;
                w_nx_mtr    = mem_to_reg;
                w_nx_rw     = reg_write;
            end
        end
    end

    // ---- stage p1: EX/MEM register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_rd3        <= '0;
            out_rc         <= '0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_reg_write  <= 1'b0;
            zero_flag      <= 1'b0;
        end else if (w_ld) begin
            out_valid      <= w_nx_valid;
            out_result     <= w_nx_result;
            out_rd3        <= w_nx_rd3;
            out_rc         <= w_nx_rc;
            out_mem_write  <= w_nx_mw;
            out_mem_to_reg <= w_nx_mtr;
            out_reg_write  <= w_nx_rw;
            zero_flag      <= w_nx_valid && (w_nx_result == '0);
        end
    end

endmodule

// File: doc/exec_vec.md
# exec_vec

Parametrised vector execute stage for the pipelined core: LANES independent WIDTH-bit ALU lanes with per-operand forwarding, an iterative multi-cycle multiplier with stall request, and the EX/MEM pipeline register. It sits between the register-read/ID stage and the memory stage, consuming hazard-unit forwarding selects and producing the registered bundle the memory stage reads.

## Interface
Parameters:
- WIDTH, 8, bits per lane (power of two, ≥4)
- LANES, 4, number of parallel lanes
- REGW, 4, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  pipeline enable; 0 freezes output register and FSM
- flush  in  1  synchronous clear of EX/MEM bundle, aborts multiply
- in_valid  in  1  instruction present
- rd1, rd2  in  LANES*WIDTH  register operands, lane i at [i*WIDTH +: WIDTH]
- imm  in  WIDTH  immediate, broadcast to all lanes
- fwd_mem, fwd_wb  in  LANES*WIDTH  forwarded results from MEM and WB
- fa, fb  in  2  forwarding select A/B: 00 reg, 01 fwd_mem, 10 fwd_wb, 11 treated as 00
- alu_ctrl  in  4  operation code
- imm_src  in  1  1: operand B = broadcast imm
- rc  in  REGW  destination register
- mem_write, mem_to_reg, reg_write  in  1  passthrough controls
- busy  out  1  stall request to hazard unit (combinational)
- out_valid  out  1  registered bundle valid
- out_result  out  LANES*WIDTH  ALU result
- out_rd3  out  LANES*WIDTH  forwarded B register value (store data, ignores imm_src)
- out_rc  out  REGW; out_mem_write, out_mem_to_reg, out_reg_write  out  1
- zero_flag  out  1  all lanes of out_result zero

## Operation
- Operand A = fa mux; B = imm_src ? imm broadcast : fb mux.
- Ops (per lane, modulo 2^WIDTH): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low WIDTH bits), 9 SLT (signed, result 1/0); others → 0. Shift amount = low log2(WIDTH) bits of B lane.
- FSM states IDLE, MUL, DONE.
- IDLE: non-MUL valid op with en loads the bundle on the next edge. MUL op with in_valid: capture operands, counter=0, → MUL.
- MUL: one shift-add step per cycle in all lanes; counter==WIDTH-1 → DONE.
- DONE: product presented as result; with en, bundle loads and → IDLE; upstream advances the held instruction on this same edge, no restart.
- busy = (state==MUL) | (state==IDLE & in_valid & alu_ctrl==MUL). Low in DONE.
- While busy, bundle loads a bubble (out_valid=0, write controls 0) when en=1.
- in_valid=0 with en loads a bubble.
- flush has priority over en: bundle cleared, FSM → IDLE, counter 0.
- en=0: all registers and FSM hold; busy still computed.

## Timing
- Reset: all outputs 0, FSM IDLE, counter 0, busy 0 (busy may rise combinationally from inputs after reset release).
- Single-cycle ops: latency 1 (result valid the edge after issue).
- MUL issued cycle t: busy high t..t+WIDTH, DONE at t+WIDTH+1, out_valid at t+WIDTH+2.
- Reset asserted mid-multiply: immediate abort, state as above.
- zero_flag registered with the bundle; 0 for bubbles.

## Configuration
- EXEC_SAT_EN defined: ADD/SUB saturate per lane to signed range (0x7F/0x80 for WIDTH=8). Undefined: wrap-around. Other ops unaffected.

## Structure
- Package exec_pkg: alu_op_e enum (codes above), fwd_sel_e enum, exec_state_e enum.
- Sub-module exec_alu_lane: combinational single-lane ALU (non-MUL ops, saturation), instantiated LANES times via generate; multiplier datapath and FSM stay in exec_vec.

## Test plan
WIDTH=8, LANES=4:
- rst=0 during MUL → all outputs 0, busy 0, FSM IDLE; after release an ADD completes normally.
- ADD rd1=0x01020304, rd2=0x10101010, fa=fb=00 → out_result 0x11121314, out_valid 1 after 1 cycle, zero_flag 0.
- SUB fa=01 fwd_mem=0x05050505, rd2=0x01010101 → 0x04040404; fb=10 fwd_wb=0x05050505 → 0x00000000, zero_flag 1.
- MUL lanes 3×5 → busy 1 for 9 cycles, out_result 0x0F0F0F0F at t+10, single out_valid pulse, no re-issue.
- ADD 0x7F+0x01 per lane → 0x80808080 without EXEC_SAT_EN, 0x7F7F7F7F with it.
- flush at t+4 of MUL → next cycle busy 0, out_valid 0, FSM IDLE; en=0 for 3 cycles mid-ADD → outputs held unchanged.
